// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage for RV32I/RV64I with a 2-entry skid buffer.
// Optional saturating illegal-entry counter is enabled by defining IMM_ILLEGAL_CNT_EN.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal
`ifdef IMM_ILLEGAL_CNT_EN
  ,
  output logic [CNT_W-1:0] illegal_cnt
`endif
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_R    = 3'd1;
  localparam logic [2:0] FMT_I    = 3'd2;
  localparam logic [2:0] FMT_S    = 3'd3;
  localparam logic [2:0] FMT_B    = 3'd4;
  localparam logic [2:0] FMT_U    = 3'd5;
  localparam logic [2:0] FMT_J    = 3'd6;
  localparam logic [2:0] FMT_ISH  = 3'd7;

  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

`ifdef IMM_ILLEGAL_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
`endif

  logic [6:0]             opc;
  logic [2:0]             f3;
  logic [5:0]             shamt;
  logic signed [31:0]     i32, s32, b32, u32, j32;
  logic signed [XLEN-1:0] imm_p0;
  logic [2:0]             fmt_p0;
  logic                   ill_p0;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign shamt = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};
  assign i32   = {{20{in_instr[31]}}, in_instr[31:20]};
  assign s32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign b32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign u32   = {in_instr[31:12], 12'h000};
  assign j32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  // Stage p0: combinational classification of the incoming word
  always_comb begin
    fmt_p0 = FMT_NONE;
    imm_p0 = '0;
    ill_p0 = 1'b0;
    case (opc)
      7'b0010011: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          fmt_p0 = FMT_ISH;
          imm_p0 = XLEN'(shamt);
          if (XLEN == 32 && in_instr[25]) ill_p0 = 1'b1;
        end else begin
          fmt_p0 = FMT_I;
          imm_p0 = sext32(i32);
        end
      end
      7'b0000011, 7'b1100111, 7'b1110011: begin
        fmt_p0 = FMT_I;
        imm_p0 = sext32(i32);
      end
      7'b0100011: begin
        fmt_p0 = FMT_S;
        imm_p0 = sext32(s32);
      end
      7'b1100011: begin
        fmt_p0 = FMT_B;
        imm_p0 = sext32(b32);
      end
      7'b0110111, 7'b0010111: begin
        fmt_p0 = FMT_U;
        imm_p0 = sext32(u32);
      end
      7'b1101111: begin
        fmt_p0 = FMT_J;
        imm_p0 = sext32(j32);
      end
      7'b0110011: fmt_p0 = FMT_R;
      default:    ill_p0 = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) ill_p0 = 1'b1;
    if (ill_p0) begin
      fmt_p0 = FMT_NONE;
      imm_p0 = '0;
    end
  end

  logic            vld_p1, skid_vld, rdy;
  logic [31:0]     instr_p1, skid_instr;
  logic [XLEN-1:0] imm_p1, skid_imm;
  logic [2:0]      fmt_p1, skid_fmt;
  logic            ill_p1, skid_ill;
  logic            acc_in, acc_out;

  assign acc_in  = in_valid && rdy;
  assign acc_out = vld_p1 && out_ready;

  // Stage p1: main entry drives the outputs, skid absorbs one beat of stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      skid_vld   <= 1'b0;
      rdy        <= 1'b1;
      instr_p1   <= '0;
      imm_p1     <= '0;
      fmt_p1     <= FMT_NONE;
      ill_p1     <= 1'b0;
      skid_instr <= '0;
      skid_imm   <= '0;
      skid_fmt   <= FMT_NONE;
      skid_ill   <= 1'b0;
    end else if (flush) begin
      vld_p1   <= 1'b0;
      skid_vld <= 1'b0;
      rdy      <= 1'b1;
    end else if (!vld_p1 || acc_out) begin
      if (skid_vld) begin
        vld_p1   <= 1'b1;
        instr_p1 <= skid_instr;
        imm_p1   <= skid_imm;
        fmt_p1   <= skid_fmt;
        ill_p1   <= skid_ill;
        skid_vld <= 1'b0;
        rdy      <= 1'b1;
      end else if (acc_in) begin
        vld_p1   <= 1'b1;
        instr_p1 <= in_instr;
        imm_p1   <= imm_p0;
        fmt_p1   <= fmt_p0;
        ill_p1   <= ill_p0;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (acc_in) begin
      skid_vld   <= 1'b1;
      skid_instr <= in_instr;
      skid_imm   <= imm_p0;
      skid_fmt   <= fmt_p0;
      skid_ill   <= ill_p0;
      rdy        <= 1'b0;
    end
  end

`ifdef IMM_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (acc_out && ill_p1)
      cnt <= sat_inc(cnt);
  end

  assign illegal_cnt = cnt;
`endif

  assign in_ready    = rdy;
  assign out_valid   = vld_p1;
  assign out_instr   = instr_p1;
  assign out_imm     = imm_p1;
  assign out_fmt     = fmt_p1;
  assign out_illegal = ill_p1;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;

  logic        rdy32, vld32, ill32;
  logic [31:0] instr32, imm32;
  logic [2:0]  fmt32;
  logic        rdy64, vld64, ill64;
  logic [31:0] instr64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
`ifdef IMM_ILLEGAL_CNT_EN
  logic [15:0] cnt32, cnt64;
`endif

  imm_decode_stage #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
    .out_valid(vld32), .out_ready(out_ready), .out_instr(instr32),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32)
`ifdef IMM_ILLEGAL_CNT_EN
    , .illegal_cnt(cnt32)
`endif
  );

  imm_decode_stage #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
    .out_valid(vld64), .out_ready(out_ready), .out_instr(instr64),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64)
`ifdef IMM_ILLEGAL_CNT_EN
    , .illegal_cnt(cnt64)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Hand-decoded vectors: instruction, XLEN=32 {imm, fmt, illegal}, XLEN=64 {imm, fmt, illegal}
  logic [31:0] v_in  [10] = '{32'hFFF00093, 32'hFE112E23, 32'h00000463, 32'h123452B7,
                              32'hFFDFF0EF, 32'h800002B7, 32'h03F09093, 32'h02009093,
                              32'h00000010, 32'h00000033};
  logic [31:0] v_i32 [10] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008, 32'h12345000,
                              32'hFFFFFFFC, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [2:0]  v_f32 [10] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd0, 3'd0, 3'd0, 3'd1};
  logic        v_l32 [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [63:0] v_i64 [10] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h8,
                              64'h0000000012345000, 64'hFFFFFFFFFFFFFFFC,
                              64'hFFFFFFFF80000000, 64'd63, 64'd32, 64'h0, 64'h0};
  logic [2:0]  v_f64 [10] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd7, 3'd7, 3'd0, 3'd1};
  logic        v_l64 [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  logic [31:0] bp [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idx, got;
    logic hs_in, hs_out;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    step; step;
    chk("rst_valid", 64'(vld32), 64'd0);
    chk("rst_ready", 64'(rdy32), 64'd1);
    chk("rst_instr", 64'(instr32), 64'd0);
    chk("rst_imm", 64'(imm32), 64'd0);
    chk("rst_fmt", 64'(fmt32), 64'd0);
    chk("rst_ill", 64'(ill32), 64'd0);
    rst_n = 1'b1;
    step;

    // Back-to-back decode stream, one result per cycle
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_instr = v_in[i];
      step;
      chk($sformatf("dec_vld[%0d]", i), 64'(vld32), 64'd1);
      chk($sformatf("dec_instr[%0d]", i), 64'(instr32), 64'(v_in[i]));
      chk($sformatf("dec32_imm[%0d]", i), 64'(imm32), 64'(v_i32[i]));
      chk($sformatf("dec32_fmt[%0d]", i), 64'(fmt32), 64'(v_f32[i]));
      chk($sformatf("dec32_ill[%0d]", i), 64'(ill32), 64'(v_l32[i]));
      chk($sformatf("dec64_imm[%0d]", i), imm64, v_i64[i]);
      chk($sformatf("dec64_fmt[%0d]", i), 64'(fmt64), 64'(v_f64[i]));
      chk($sformatf("dec64_ill[%0d]", i), 64'(ill64), 64'(v_l64[i]));
    end
    in_valid = 1'b0;
    step;
    chk("dec_idle_vld", 64'(vld32), 64'd0);

    // Back-pressure: only two entries fit while the consumer stalls
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = bp[0];
    step;
    chk("bp_first_rdy", 64'(rdy32), 64'd1);
    chk("bp_first_vld", 64'(vld32), 64'd1);
    in_instr = bp[1];
    step;
    chk("bp_rdy_drop", 64'(rdy32), 64'd0);
    in_instr = bp[2];
    step; step;
    chk("bp_rdy_low", 64'(rdy32), 64'd0);
    chk("bp_hold_instr", 64'(instr32), 64'(bp[0]));
    chk("bp_hold_vld", 64'(vld32), 64'd1);

    idx = 2;
    got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      hs_out = vld32 && out_ready;
      hs_in  = in_valid && rdy32;
      if (hs_out) begin
        chk($sformatf("bp_order[%0d]", got), 64'(instr32), 64'(bp[got]));
        got++;
      end
      if (hs_in) idx++;
      step;
      if (c == 0) chk("bp_rdy_rise", 64'(rdy32), 64'd1);
      if (idx < 4) begin
        in_valid = 1'b1;
        in_instr = bp[idx];
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("bp_delivered", 64'(got), 64'd4);
    chk("bp_drained", 64'(vld32), 64'd0);

    // Flush beats a same-cycle accept with only main occupied
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = bp[0];
    step;
    flush    = 1'b1;
    in_instr = bp[3];
    step;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush1_vld", 64'(vld32), 64'd0);
    chk("flush1_rdy", 64'(rdy32), 64'd1);
    step;
    chk("flush1_discard", 64'(vld32), 64'd0);

    // Flush with both entries full and input still offered
    in_valid = 1'b1;
    in_instr = bp[1];
    step;
    in_instr = bp[2];
    step;
    chk("flush2_full", 64'(rdy32), 64'd0);
    flush    = 1'b1;
    in_instr = bp[3];
    step;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush2_vld", 64'(vld32), 64'd0);
    chk("flush2_rdy", 64'(rdy32), 64'd1);
    out_ready = 1'b1;
    step; step;
    chk("flush2_discard", 64'(vld32), 64'd0);

`ifdef IMM_ILLEGAL_CNT_EN
    chk("cnt32", 64'(cnt32), 64'd3);
    chk("cnt64", 64'(cnt64), 64'd1);
`endif

    // Reset while stalled with both entries full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = bp[0];
    step;
    in_instr = bp[1];
    step;
    chk("mrst_full", 64'(rdy32), 64'd0);
    rst_n    = 1'b0;
    in_instr = bp[2];
    step;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("mrst_vld", 64'(vld32), 64'd0);
    chk("mrst_rdy", 64'(rdy32), 64'd1);
    chk("mrst_instr", 64'(instr32), 64'd0);
    chk("mrst_imm", 64'(imm32), 64'd0);
    chk("mrst_fmt", 64'(fmt32), 64'd0);
    chk("mrst_ill", 64'(ill32), 64'd0);
    chk("mrst_imm64", imm64, 64'd0);
    chk("mrst_vld64", 64'(vld64), 64'd0);
`ifdef IMM_ILLEGAL_CNT_EN
    chk("mrst_cnt", 64'(cnt32), 64'd0);
`endif
    step;
    chk("mrst_after_vld", 64'(vld32), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Pipelined immediate-decode stage between instruction fetch and the execute datapath. It accepts one 32-bit instruction per handshake, classifies its format, and produces the sign-extended immediate at width XLEN together with a format code and an illegal flag. It sits behind valid/ready handshakes on both sides, with a 2-entry skid buffer so back-pressure from execute never forms a combinational path to fetch. It covers all RV32I/RV64I immediate formats (I, S, B, U, J, shift-immediate).

## Interface
- XLEN, default 32: datapath width; legal values 32 or 64.
- CNT_W, default 16: width of the illegal-instruction counter (used only with the configuration macro).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- out_valid  out  1  decoded entry present.
- out_ready  in  1  consumer accepts.
- out_instr  out  32  instruction word of the output entry.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  format code: 0 NONE, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J, 7 ISH (shift-immediate).
- out_illegal  out  1  unsupported encoding.
- illegal_cnt  out  CNT_W  saturating count of illegal entries delivered (present only with IMM_ILLEGAL_CNT_EN).

## Operation
- The stage accepts an instruction when in_valid && in_ready. Decode is combinational on in_instr; the result is stored in the buffer.
- Opcode classes:
  - 0010011, 0000011, 1100111, 1110011 → I: imm = sext(instr[31:20]).
  - 0100011 → S: imm = sext({instr[31:25], instr[11:7]}).
  - 1100011 → B: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111, 0010111 → U: imm = sext({instr[31:12], 12'h000}).
  - 1101111 → J: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 0110011 → R: imm = 0.
- Shift-immediates (opcode 0010011, funct3 001 or 101) → ISH: imm is the zero-extended shamt. The shamt is instr[24:20] when XLEN=32 and instr[25:20] when XLEN=64.
  - When XLEN=32 and instr[25]=1: illegal.
- sext means sign-extend from instr[31] to XLEN bits. For U with XLEN=64, bits 63:32 copy instr[31].
- Illegal cases: instr[1:0] != 2'b11, an unlisted opcode, or a bad RV32 shamt. Each gives out_fmt=0, out_imm=0, out_illegal=1. The entry is still delivered; it is not dropped.
- Buffer is two entries: main (drives outputs) and skid.
  - Empty: an accept loads main.
  - Main full, output accepted, input accepted: main reloads from the new input.
  - Main full, output stalled, input accepted: the new entry goes to skid; in_ready drops the next cycle.
  - Both full and output accepted: skid moves to main; in_ready rises the next cycle.
- Order is strictly FIFO; no entry is duplicated or lost.
- flush empties both entries and has priority over a same-cycle input accept (that input is discarded). It does not clear illegal_cnt.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is on the outputs with out_valid=1 after edge N.
- Throughput is 1 per cycle when out_ready=1 continuously.
- in_ready is a registered signal. in_ready = !skid_full. There is no combinational path from out_ready to in_ready.
- Outputs hold stable while out_valid && !out_ready.
- Reset values: out_valid=0, in_ready=1, out_instr=0, out_imm=0, out_fmt=0, out_illegal=0, illegal_cnt=0.
- Reset in the middle of a stall discards both entries. Reset has priority over flush and over an input accept.

## Configuration
- IMM_ILLEGAL_CNT_EN defined:
  - illegal_cnt exists.
  - It increments on each output handshake with out_illegal=1.
  - It saturates at 2^CNT_W-1.
  - Entries removed by flush are not counted.
- IMM_ILLEGAL_CNT_EN undefined: no illegal_cnt port and no counter logic; all other behaviour is identical.

## Test plan
- Format decode, XLEN=32, out_ready=1:
  - 0xFFF00093 → imm 0xFFFFFFFF, fmt 2.
  - 0xFE112E23 → imm 0xFFFFFFFC, fmt 3.
  - 0x00000463 → imm 0x00000008, fmt 4.
  - 0x123452B7 → imm 0x12345000, fmt 5.
  - 0xFFDFF0EF → imm 0xFFFFFFFC, fmt 6.
  - Each appears 1 cycle after acceptance.
- XLEN=64:
  - 0x123452B7 → imm 0x0000000012345000.
  - 0x800002B7 → 0xFFFFFFFF80000000.
  - slli 0x03F09093 → fmt 7, imm 63.
- Illegal, XLEN=32:
  - 0x02009093 → illegal=1, fmt 0, imm 0.
  - 0x00000013 with bits[1:0]=00 (0x00000010) → illegal=1.
  - With IMM_ILLEGAL_CNT_EN, illegal_cnt=2 after both are delivered.
- Back-pressure: stream of 4 instructions with out_ready=0 from cycle 1.
  - Only 2 are accepted; in_ready=0 after the second.
  - Releasing out_ready delivers all 4 in order with no loss or duplication.
- Flush with both entries full and in_valid=1 in the same cycle:
  - Next cycle: out_valid=0, in_ready=1.
  - The flushed input never appears on the output.
- Reset mid-stall (rst_n=0 for one cycle, both entries full): all outputs return to their reset values and in_ready=1.
